// File: rtl/fetch_queue.sv
// Instruction-fetch stage: keeps one RAM read in flight and buffers {pc, ir} pairs in a DEPTH-entry queue ahead of decode.
// Optional build macro FETCH_PERF_EN adds the perf_stall back-pressure counter port.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump,
  input  logic [WORD_WIDTH-1:0] target,
  output logic                  ram_en_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [WORD_WIDTH-1:0] ram_rdata_b,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [WORD_WIDTH-1:0] pc_id,
  output logic [WORD_WIDTH-1:0] ir_id
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           perf_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_WIDTH-1:0] fpc;
  logic                  pending;
  logic [WORD_WIDTH-1:0] pending_pc;
  logic [WORD_WIDTH-1:0] pc_q [DEPTH];
  logic [WORD_WIDTH-1:0] ir_q [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic [CNT_W:0]        occupancy;
  logic                  push;
  logic                  pop;

  // Space is reserved for the in-flight read, and a pop this cycle does not
  // free a slot, so the queue can never overflow.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  assign ram_en_b  = !rst && !jump && (occupancy < (CNT_W + 1)'(DEPTH));
  assign ram_addr_b = fpc[ADDR_WIDTH-1:0];

  // id_valid/id_ready: the head transfers to decode on every cycle where both
  // are high; id_valid never depends on id_ready.
  assign id_valid = !rst && (count != '0);
  assign push     = pending;
  assign pop      = id_valid && id_ready;

  always_comb begin
    pc_id = fpc;
    ir_id = '0;
    if (rst) begin
      pc_id = BOOT_ADDR;
    end else if (count != '0) begin
      pc_id = pc_q[head];
      ir_id = ir_q[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc        <= BOOT_ADDR;
      pending    <= 1'b0;
      pending_pc <= BOOT_ADDR;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else if (jump) begin
      // Flush: queued entries and the in-flight word are dropped.
      fpc     <= target;
      pending <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        pc_q[tail] <= pending_pc;
        ir_q[tail] <= ram_rdata_b;
        tail       <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ram_en_b) begin
        fpc        <= fpc + WORD_WIDTH'(1);
        pending    <= 1'b1;
        pending_pc <= fpc;
      end else begin
        pending <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
    end else if (id_valid && !id_ready && (perf_stall != 16'hFFFF)) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
